sm_matrix_xpose: RTL and testbench

Bus initiator that transposes, in place, the 4x4 matrix of 32-bit words held by the `sm_matrix` responder. It drives the responder's bus port (`bAddr`/`bWrite`/`bWData`) and consumes its read data (`bRData`), swapping each off-diagonal pair (r,c)/(c,r). It sits between the processor-side control logic and the matrix store, and is triggered by a single-cycle `start` pulse.

---
 rtl/sm_matrix_xpose_pkg.sv | 22 ++
 rtl/sm_matrix_pair_gen.sv | 58 +++++
 rtl/sm_matrix_xpose.sv | 152 +++++++++++++++
 tb/tb_sm_matrix_xpose.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm_matrix_xpose_pkg.sv
// ---------------------------------------------------------------------------
// sm_matrix_xpose_pkg
// Shared definitions for the in-place 4x4 matrix transpose initiator:
// controller state encoding and matrix geometry constants.
// ---------------------------------------------------------------------------
package sm_matrix_xpose_pkg;

  localparam int SM_MAT_DIM    = 4;
  localparam int SM_MAT_AW     = 4;  // {row[1:0], col[1:0]}
  localparam int SM_MAT_NPAIRS = 6;  // off-diagonal pairs in a 4x4 matrix
  localparam int SM_MAT_PW     = 3;  // width of the pair counter

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_DONE = 3'd5
  } xpose_state_t;

endpackage

// File: rtl/sm_matrix_pair_gen.sv
// ---------------------------------------------------------------------------
// sm_matrix_pair_gen
// Walks the six upper-triangle pairs (r,c) = (0,1),(0,2),(0,3),(1,2),(1,3),
// (2,3) and presents the word addresses of both halves of the pair.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          return the counter to pair 0 (wins over adv)
//   adv          step to the next pair
//   addr_a       r*4+c  (upper-triangle word)
//   addr_b       c*4+r  (mirrored lower-triangle word)
//   last         current pair is the final one
// ---------------------------------------------------------------------------
module sm_matrix_pair_gen
  import sm_matrix_xpose_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 adv,
  output logic [SM_MAT_AW-1:0] addr_a,
  output logic [SM_MAT_AW-1:0] addr_b,
  output logic                 last
);

  logic [SM_MAT_PW-1:0] p;
  logic [1:0]           row;
  logic [1:0]           col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (clr) begin
      p <= '0;
    end else if (adv) begin
      p <= p + 1'b1;
    end
  end

  always_comb begin
    row = 2'd0;
    col = 2'd0;
    case (p)
      3'd0: begin row = 2'd0; col = 2'd1; end
      3'd1: begin row = 2'd0; col = 2'd2; end
      3'd2: begin row = 2'd0; col = 2'd3; end
      3'd3: begin row = 2'd1; col = 2'd2; end
      3'd4: begin row = 2'd1; col = 2'd3; end
      3'd5: begin row = 2'd2; col = 2'd3; end
      default: begin row = 2'd0; col = 2'd0; end
    endcase
    addr_a = {row, col};
    addr_b = {col, row};
  end

  assign last = (p == SM_MAT_PW'(SM_MAT_NPAIRS - 1));

endmodule

// File: rtl/sm_matrix_xpose.sv
// ---------------------------------------------------------------------------
// sm_matrix_xpose
// Bus initiator that transposes the 4x4 word matrix held by the sm_matrix
// responder in place. For each off-diagonal pair it reads A, reads B, writes
// mem[B] to A and the saved mem[A] to B. Diagonal words are never touched.
//
// Optional feature macro: SM_MATRIX_XPOSE_SUM_EN adds the 'sum' output, a
// 32-bit wrap-around total of every off-diagonal word read during a run.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle request, honoured only while idle
//   busy         high over the 24 bus cycles of a run
//   done         one-cycle pulse after the final write
//   bAddr        bus address {28'b0, row, col}
//   bWrite       bus write enable
//   bWData       bus write data
//   bRData       responder read data, one cycle after a read address
//   sum          (SM_MATRIX_XPOSE_SUM_EN only) accumulated read data
// ---------------------------------------------------------------------------
module sm_matrix_xpose
  import sm_matrix_xpose_pkg::*;
#(
  parameter int DIM    = 4,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] bAddr,
  output logic        bWrite,
  output logic [31:0] bWData,
  input  logic [31:0] bRData
`ifdef SM_MATRIX_XPOSE_SUM_EN
  ,
  output logic [31:0] sum
`endif
);

  // The address map and state sequence are built for a 4x4 matrix behind a
  // single-cycle read responder; any other setting is a build error.
  if (DIM != SM_MAT_DIM || RD_LAT != 1) begin : g_cfg_check
    $error("sm_matrix_xpose supports only DIM=4 and RD_LAT=1");
  end

  xpose_state_t         state;
  xpose_state_t         state_next;
  logic [SM_MAT_AW-1:0] addr_a;
  logic [SM_MAT_AW-1:0] addr_b;
  logic                 last;
  logic                 accept;
  logic                 pair_adv;
  logic [SM_MAT_AW-1:0] addr;
  logic [31:0]          reg_a;

  assign accept   = (state == ST_IDLE) && start;
  assign pair_adv = (state == ST_WR_B) && !last;

  sm_matrix_pair_gen u_pair_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .adv    (pair_adv),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RD_A;
      ST_RD_A: state_next = ST_RD_B;
      ST_RD_B: state_next = ST_WR_A;
      ST_WR_A: state_next = ST_WR_B;
      ST_WR_B: state_next = last ? ST_DONE : ST_RD_A;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus outputs are a pure decode of state, pair addresses and reg_a, so an
  // asynchronous reset drops them to zero immediately. In WR_A the read data
  // of B is forwarded straight to the write bus; B never needs its own
  // holding register because it is consumed in the cycle it arrives.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    addr   = '0;
    bWrite = 1'b0;
    bWData = '0;
    case (state)
      ST_RD_A: begin
        busy = 1'b1;
        addr = addr_a;
      end
      ST_RD_B: begin
        busy = 1'b1;
        addr = addr_b;
      end
      ST_WR_A: begin
        busy   = 1'b1;
        addr   = addr_a;
        bWrite = 1'b1;
        bWData = bRData;
      end
      ST_WR_B: begin
        busy   = 1'b1;
        addr   = addr_b;
        bWrite = 1'b1;
        bWData = reg_a;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign bAddr = {{(32 - SM_MAT_AW){1'b0}}, addr};

  // mem[A] arrives during RD_B and is held until it is written to B in WR_B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a <= '0;
    end else if (state == ST_RD_B) begin
      reg_a <= bRData;
    end
  end

`ifdef SM_MATRIX_XPOSE_SUM_EN
  // Read data is valid on bRData in RD_B (mem[A]) and WR_A (mem[B]).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (accept) begin
      sum <= '0;
    end else if (state == ST_RD_B || state == ST_WR_A) begin
      sum <= sum + bRData;
    end
  end
`endif

endmodule

// File: tb/tb_sm_matrix_xpose.sv
// ---------------------------------------------------------------------------
// tb_sm_matrix_xpose
// Self-checking bench for sm_matrix_xpose. A 16-word responder with one
// cycle of read latency lives in the bench. Expected bus writes are queued
// from a transpose reference model and consumed by an independent monitor.
// ---------------------------------------------------------------------------
module tb_sm_matrix_xpose;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] bAddr;
  logic        bWrite;
  logic [31:0] bWData;
  logic [31:0] bRData;
`ifdef SM_MATRIX_XPOSE_SUM_EN
  logic [31:0] sum;
`endif

  int checks = 0;
  int errors = 0;

  // Responder memory and preload path.
  logic [31:0] mem    [16];
  logic [31:0] ld_mem [16];
  logic        ld;

  // Reference model state.
  logic [31:0] ref_mem  [16];
  logic [31:0] next_mem [16];
  logic [31:0] exp_sum;
  logic [3:0]  exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  sm_matrix_xpose dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .bAddr  (bAddr),
    .bWrite (bWrite),
    .bWData (bWData),
    .bRData (bRData)
`ifdef SM_MATRIX_XPOSE_SUM_EN
    ,
    .sum    (sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 16; i++) mem[i] <= ld_mem[i];
    end else if (bWrite) begin
      mem[bAddr[3:0]] <= bWData;
    end
    bRData <= mem[bAddr[3:0]];
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every bus write must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && bWrite) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", bAddr, bWData);
      end else begin
        check32("wr_addr", bAddr, {28'd0, exp_addr_q.pop_front()});
        check32("wr_data", bWData, exp_data_q.pop_front());
      end
    end
  end

  task automatic load(input logic [31:0] vals [16]);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      ld_mem[i]  = vals[i];
      ref_mem[i] = vals[i];
    end
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Reference: the transposed matrix, and the write sequence (A gets old B,
  // B gets old A) walking the upper triangle row by row.
  task automatic push_expected();
    exp_sum = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) next_mem[r*4+c] = ref_mem[c*4+r];
      for (int c = r + 1; c < 4; c++) begin
        exp_addr_q.push_back(4'(r*4+c));
        exp_data_q.push_back(ref_mem[c*4+r]);
        exp_addr_q.push_back(4'(c*4+r));
        exp_data_q.push_back(ref_mem[r*4+c]);
        exp_sum = exp_sum + ref_mem[r*4+c] + ref_mem[c*4+r];
      end
    end
  endtask

  // One full run with cycle-accurate busy/done checks. A stray start pulse
  // can be driven during cycle 'stray'.
  task automatic do_run(input int stray);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      start = (k == stray);
      check32($sformatf("busy_c%0d", k), {31'd0, busy}, {31'd0, (k <= 24)});
      check32($sformatf("done_c%0d", k), {31'd0, done}, {31'd0, (k == 25)});
`ifdef SM_MATRIX_XPOSE_SUM_EN
      if (k == 25) check32("sum_at_done", sum, exp_sum);
`endif
    end
    start = 1'b0;
    check32("writes_left", exp_addr_q.size(), 32'd0);
    for (int i = 0; i < 16; i++) ref_mem[i] = next_mem[i];
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++)
      check32($sformatf("%s_mem%0d", tag, i), mem[i], ref_mem[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check32({tag, "_busy"},   {31'd0, busy},   32'd0);
    check32({tag, "_done"},   {31'd0, done},   32'd0);
    check32({tag, "_bAddr"},  bAddr,           32'd0);
    check32({tag, "_bWrite"}, {31'd0, bWrite}, 32'd0);
    check32({tag, "_bWData"}, bWData,          32'd0);
`ifdef SM_MATRIX_XPOSE_SUM_EN
    check32({tag, "_sum"},    sum,             32'd0);
`endif
  endtask

  initial begin
    logic [31:0] vals [16];
    logic [31:0] orig [16];

    rst_n = 1'b0;
    start = 1'b0;
    ld    = 1'b0;
    for (int i = 0; i < 16; i++) ld_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Basic transpose on mem[i] = i.
    for (int i = 0; i < 16; i++) vals[i] = 32'(i);
    load(vals);
    do_run(0);
    check32("basic_mem1",  mem[1],  32'd4);
    check32("basic_mem4",  mem[4],  32'd1);
    check32("basic_mem11", mem[11], 32'd14);
    check32("basic_mem14", mem[14], 32'd11);
    check32("basic_mem0",  mem[0],  32'd0);
    check32("basic_mem5",  mem[5],  32'd5);
    check32("basic_mem10", mem[10], 32'd10);
    check32("basic_mem15", mem[15], 32'd15);
    check_mem("basic");

    // Double transpose on random data returns the original matrix.
    for (int i = 0; i < 16; i++) begin
      vals[i] = $urandom;
      orig[i] = vals[i];
    end
    load(vals);
    do_run(0);
    check_mem("dbl1");
    do_run(0);
    for (int i = 0; i < 16; i++) check32($sformatf("dbl_orig%0d", i), mem[i], orig[i]);

    // Stray start in cycle 10 is ignored; no second run follows.
    for (int i = 0; i < 16; i++) vals[i] = $urandom;
    load(vals);
    do_run(10);
    repeat (4) begin
      @(negedge clk);
      check32("no_rerun_busy", {31'd0, busy}, 32'd0);
    end
    check_mem("stray");

    // All-ones matrix: sum wraps to 0xFFFFFFF4.
    for (int i = 0; i < 16; i++) vals[i] = 32'hFFFF_FFFF;
    load(vals);
    do_run(0);
`ifdef SM_MATRIX_XPOSE_SUM_EN
    check32("ones_sum", sum, 32'hFFFF_FFF4);
`endif
    check_mem("ones");

    // Reset abort in cycle 7: pair 0 done, pair 1 never written.
    for (int i = 0; i < 16; i++) vals[i] = 32'(i);
    load(vals);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("abort");
    exp_addr_q.delete();
    exp_data_q.delete();
    ref_mem[1] = 32'd4;
    ref_mem[4] = 32'd1;
    repeat (2) @(negedge clk);
    check_idle_outputs("abort_hold");
    rst_n = 1'b1;
    check32("abort_mem1", mem[1], 32'd4);
    check32("abort_mem4", mem[4], 32'd1);
    check32("abort_mem2", mem[2], 32'd2);
    check_mem("abort");
    do_run(0);
    check_mem("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
